// File: rtl/video_in_gen.sv
// video_in_gen: camera-side test-pattern video source.
// Emits blanked frames with four selectable patterns, one pixel per clk.
module video_in_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 160,
   parameter int V_ACTIVE = 480,
   parameter int V_BLANK  = 45
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        line_valid,
   output logic        frame_valid,
   output logic [7:0]  pixel_out,
   output logic        frame_start,
   output logic [15:0] frame_cnt,
   output logic        busy
);

   localparam int H_TOTAL = H_BLANK + H_ACTIVE;
   localparam int V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [HW-1:0]  h_q, h_d;
   logic [VW-1:0]  v_q, v_d;
   logic [1:0]     pattern_q, pattern_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;
   logic           start_d;

   logic           lv_q, lv_d;
   logic           fv_q, fv_d;
   logic [7:0]     pix_q, pix_d;
   logic           fs_q;
   logic           busy_q, busy_d;

   logic [7:0]     x_d;
   logic [7:0]     y_d;

   // Next raster position, pattern latch and frame counter.
   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      v_d         = v_q;
      pattern_d   = pattern_q;
      frame_cnt_d = frame_cnt_q;
      start_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d   = RUN;
               h_d       = '0;
               v_d       = '0;
               pattern_d = pattern_sel;
               start_d   = 1'b1;
            end
         end
         RUN: begin
            if (h_q == H_LAST) begin
               h_d = '0;
               if (v_q == V_LAST) begin
                  v_d         = '0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  if (enable) begin
                     pattern_d = pattern_sel;
                     start_d   = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  v_d = v_q + VW'(1);
               end
            end else begin
               h_d = h_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output values for the position the raster moves to at this edge.
   always_comb begin
      busy_d = (state_d == RUN);
      fv_d   = busy_d && (int'(v_d) < V_ACTIVE);
      lv_d   = fv_d && (int'(h_d) >= H_BLANK);
      x_d    = 8'(h_d) - 8'(H_BLANK);
      y_d    = 8'(v_d);
      pix_d  = 8'h00;
      if (lv_d) begin
         unique case (pattern_d)
            2'd0: pix_d = x_d;
            2'd1: pix_d = y_d;
            2'd2: pix_d = (x_d[3] ^ y_d[3]) ? 8'hFF : 8'h00;
            2'd3: pix_d = x_d + y_d + frame_cnt_d[7:0];
            default: pix_d = 8'h00;
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         h_q         <= '0;
         v_q         <= '0;
         pattern_q   <= 2'd0;
         frame_cnt_q <= 16'd0;
         lv_q        <= 1'b0;
         fv_q        <= 1'b0;
         pix_q       <= 8'h00;
         fs_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         v_q         <= v_d;
         pattern_q   <= pattern_d;
         frame_cnt_q <= frame_cnt_d;
         lv_q        <= lv_d;
         fv_q        <= fv_d;
         pix_q       <= pix_d;
         fs_q        <= start_d;
         busy_q      <= busy_d;
      end
   end

   assign line_valid  = lv_q;
   assign frame_valid = fv_q;
   assign pixel_out   = pix_q;
   assign frame_start = fs_q;
   assign frame_cnt   = frame_cnt_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_video_in_gen.sv
// tb_video_in_gen: directed bench for video_in_gen with a frame-position
// reference model checked every cycle plus literal expectations.
module tb_video_in_gen;

   localparam int H_ACTIVE = 8;
   localparam int H_BLANK  = 4;
   localparam int V_ACTIVE = 4;
   localparam int V_BLANK  = 2;
   localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
   localparam int V_TOTAL  = V_ACTIVE + V_BLANK;
   localparam int FRAME    = H_TOTAL * V_TOTAL;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        line_valid;
   logic        frame_valid;
   logic [7:0]  pixel_out;
   logic        frame_start;
   logic [15:0] frame_cnt;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   video_in_gen #(
      .H_ACTIVE(H_ACTIVE),
      .H_BLANK (H_BLANK),
      .V_ACTIVE(V_ACTIVE),
      .V_BLANK (V_BLANK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .pattern_sel(pattern_sel),
      .line_valid (line_valid),
      .frame_valid(frame_valid),
      .pixel_out  (pixel_out),
      .frame_start(frame_start),
      .frame_cnt  (frame_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference model: position within the frame, latched pattern, count.
   bit          m_run  = 1'b0;
   int          m_t    = 0;
   logic [1:0]  m_pat  = 2'd0;
   logic [15:0] m_fcnt = 16'd0;

   function automatic logic [7:0] exp_pix(input logic [1:0] p, input int x,
                                          input int y, input logic [7:0] fc);
      logic [7:0] r;
      case (p)
         2'd0: r = 8'(x % 256);
         2'd1: r = 8'(y % 256);
         2'd2: r = (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
         default: r = 8'((x + y + int'(fc)) % 256);
      endcase
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_run  = 1'b0;
         m_t    = 0;
         m_pat  = 2'd0;
         m_fcnt = 16'd0;
      end else if (!m_run) begin
         if (enable) begin
            m_run = 1'b1;
            m_t   = 0;
            m_pat = pattern_sel;
         end
      end else if (m_t == FRAME - 1) begin
         m_fcnt = m_fcnt + 16'd1;
         if (enable) begin
            m_t   = 0;
            m_pat = pattern_sel;
         end else begin
            m_run = 1'b0;
         end
      end else begin
         m_t = m_t + 1;
      end
   end

   function automatic logic [27:0] model_out();
      int         h, v;
      logic       fv, lv, fs;
      logic [7:0] p;
      if (!m_run) return {12'h000, m_fcnt};
      h  = m_t % H_TOTAL;
      v  = m_t / H_TOTAL;
      fv = (v < V_ACTIVE);
      lv = fv && (h >= H_BLANK);
      fs = (m_t == 0);
      p  = lv ? exp_pix(m_pat, h - H_BLANK, v, m_fcnt[7:0]) : 8'h00;
      return {fs, fv, lv, 1'b1, p, m_fcnt};
   endfunction

   // Every-cycle comparison against the model, away from the clock edge.
   always @(negedge clk) begin
      logic [27:0] e, a;
      e = model_out();
      a = {frame_start, frame_valid, line_valid, busy, pixel_out, frame_cnt};
      n_assert++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL cycle_cmp t=%0t: got fs/fv/lv/busy/pix/cnt=%b%b%b%b/%02h/%04h required %b%b%b%b/%02h/%04h",
                  $time, a[27], a[26], a[25], a[24], a[23:16], a[15:0],
                  e[27], e[26], e[25], e[24], e[23:16], e[15:0]);
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int         nlv, nfv, nfs, first_lv, last_lv;
   logic [7:0] cap[$];

   // Sample one whole frame starting on its first cycle.
   task automatic capture(input int chg_at, input logic [1:0] chg_sel,
                          input int dis_at);
      nlv = 0;
      nfv = 0;
      nfs = 0;
      first_lv = -1;
      last_lv  = -1;
      cap.delete();
      for (int i = 0; i < FRAME; i++) begin
         if (i == chg_at) pattern_sel = chg_sel;
         if (i == dis_at) enable = 1'b0;
         if (line_valid) begin
            if (first_lv < 0) first_lv = i;
            last_lv = i;
            cap.push_back(pixel_out);
         end
         nlv += int'(line_valid);
         nfv += int'(frame_valid);
         nfs += int'(frame_start);
         tick(1);
      end
   endtask

   function automatic int bad_pix(input logic [1:0] p, input logic [7:0] fc);
      int bad = 0;
      if (cap.size() != H_ACTIVE * V_ACTIVE) return 999;
      for (int k = 0; k < H_ACTIVE * V_ACTIVE; k++)
         if (cap[k] !== exp_pix(p, k % H_ACTIVE, k / H_ACTIVE, fc)) bad++;
      return bad;
   endfunction

   initial begin
      #1 reset = 1'b1;
      tick(3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fv", 32'(frame_valid), 0);
      chk("rst_cnt", 32'(frame_cnt), 0);
      reset = 1'b0;
      tick(2);
      chk("idle_busy", 32'(busy), 0);

      // Frame A: horizontal ramp, pattern change mid-frame ignored.
      enable = 1'b1;
      pattern_sel = 2'd0;
      tick(1);
      chk("a_fs", 32'(frame_start), 1);
      chk("a_busy", 32'(busy), 1);
      chk("a_fv0", 32'(frame_valid), 1);
      chk("a_lv0", 32'(line_valid), 0);
      capture(30, 2'd1, -1);
      chk("a_nlv", 32'(nlv), 32);
      chk("a_nfv", 32'(nfv), 48);
      chk("a_nfs", 32'(nfs), 1);
      chk("a_first_lv", 32'(first_lv), 4);
      chk("a_last_lv", 32'(last_lv), 47);
      chk("a_hramp", 32'(bad_pix(2'd0, 8'd0)), 0);
      chk("a_period_fs", 32'(frame_start), 1);
      chk("a_cnt", 32'(frame_cnt), 1);

      // Frame B: vertical ramp.
      capture(30, 2'd3, -1);
      chk("b_vramp", 32'(bad_pix(2'd1, 8'd0)), 0);
      chk("b_l3_px", 32'(cap[24]), 3);
      chk("b_cnt", 32'(frame_cnt), 2);

      // Frame C: moving diagonal with frame_cnt = 2.
      capture(30, 2'd2, -1);
      chk("c_l1_first", 32'(cap[8]), 3);
      chk("c_l1_last", 32'(cap[15]), 10);
      chk("c_diag", 32'(bad_pix(2'd3, 8'd2)), 0);
      chk("c_cnt", 32'(frame_cnt), 3);

      // Frame D: checker, all zero within the first 8x8 block.
      capture(30, 2'd0, -1);
      chk("d_nlv", 32'(nlv), 32);
      chk("d_checker", 32'(bad_pix(2'd2, 8'd3)), 0);

      // Frame E: enable dropped at cycle 20, frame still completes.
      capture(-1, 2'd0, 20);
      chk("e_nlv", 32'(nlv), 32);
      chk("e_busy_drop", 32'(busy), 0);
      chk("e_fs", 32'(frame_start), 0);
      chk("e_cnt", 32'(frame_cnt), 5);
      tick(5);
      chk("e_idle_fv", 32'(frame_valid), 0);
      chk("e_idle_pix", 32'(pixel_out), 0);
      chk("e_idle_cnt", 32'(frame_cnt), 5);

      // Frame F/G: frame counter wrap.
      enable = 1'b1;
      pattern_sel = 2'd3;
      tick(1);
      chk("f_fs", 32'(frame_start), 1);
      force dut.frame_cnt_d = 16'hFFFF;
      tick(1);
      release dut.frame_cnt_d;
      m_fcnt = 16'hFFFF;
      chk("f_forced", 32'(frame_cnt), 32'h0000FFFF);
      tick(FRAME - 1);
      chk("g_wrap_cnt", 32'(frame_cnt), 0);
      chk("g_fs", 32'(frame_start), 1);
      capture(-1, 2'd3, -1);
      chk("g_nlv", 32'(nlv), 32);
      chk("g_l0_last", 32'(cap[7]), 7);
      chk("g_diag", 32'(bad_pix(2'd3, 8'd0)), 0);
      chk("g_cnt", 32'(frame_cnt), 1);

      // Frame H: asynchronous reset mid-line.
      tick(17);
      chk("h_pre_lv", 32'(line_valid), 1);
      chk("h_pre_pix", 32'(pixel_out), 3);
      #2 reset = 1'b1;
      #1;
      chk("h_rst_lv", 32'(line_valid), 0);
      chk("h_rst_fv", 32'(frame_valid), 0);
      chk("h_rst_pix", 32'(pixel_out), 0);
      chk("h_rst_busy", 32'(busy), 0);
      chk("h_rst_cnt", 32'(frame_cnt), 0);
      tick(2);
      reset = 1'b0;
      tick(1);
      chk("h_restart_fs", 32'(frame_start), 1);
      chk("h_restart_busy", 32'(busy), 1);
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
